adpll_loop_sequencer: RTL and testbench
=======================================

// Module: adpll_loop_sequencer
// PURPOSE
//  Bring-up and gain-scheduling controller for the ADPLL core top.
//  Drives the top's programming port (pgm/param_sel/pgm_value) and its core reset (rst).
//  Programs all six parameters with acquisition gains, then releases the loop.
//  Watches the filter output (out_sel=0) for lock, then switches alpha/beta to tracking gains.
//  If lock is lost it returns to acquisition gains. Runs entirely in the clk domain.
// PARAMETERS
//  LOCK_TOL     2     lock window: |filter| <= LOCK_TOL counts as in-window
//  LOCK_CNT     64    consecutive in-window cycles required to declare lock
//  UNLOCK_TOL   6     |filter| > UNLOCK_TOL counts as out-of-window while tracking
//  UNLOCK_CNT   8     consecutive out-of-window cycles that declare loss of lock
//  RST_CYCLES   4     cycles the core reset is held after programming
//  ACQ_TIMEOUT  4096  maximum number of ACQ cycles before fail
// PORTS
//  clk          in   1   system clock (TT clock, same as the ADPLL top)
//  clr          in   1   reset: asynchronous, active-high
//  start        in   1   level; sampled in IDLE only; begins the bring-up sequence
//  stop         in   1   level; forces IDLE from any state; highest priority
//  cfg_ndiv     in   4   feedback divider value
//  cfg_acq_a    in   5   alpha used during acquisition
//  cfg_acq_b    in   5   beta used during acquisition
//  cfg_trk_a    in   5   alpha used during tracking
//  cfg_trk_b    in   5   beta used during tracking
//  cfg_offset   in   5   DCO offset
//  cfg_thresh   in   5   DCO threshold
//  cfg_kdco     in   5   DCO gain
//  filt_mag     in   5   filter magnitude (dout of the ADPLL top, out_sel=0)
//  pgm          out  1   programming strobe to the ADPLL top
//  param_sel    out  3   parameter select: 0=ndiv 1=alpha 2=beta 3=offset 4=thresh 5=kdco
//  pgm_value    out  5   value to program; ndiv is zero-extended
//  core_rst     out  1   drives the rst input of the ADPLL top
//  out_sel      out  1   tied to 0 (filter output selected)
//  locked       out  1   high only while in TRACK
//  fail         out  1   sticky acquisition-timeout flag; cleared when start is accepted
//  relock_cnt   out  8   number of TRACK->RELOAD transitions; saturates at 255
//  state        out  3   current FSM state code (debug)
// BEHAVIOUR
//  All outputs are registered.
//  Reset values: pgm=0, param_sel=0, pgm_value=0, core_rst=1, locked=0, fail=0,
//   relock_cnt=0, state=IDLE, all counters 0.
//  State codes: IDLE=0, LOAD=1, RELEASE=2, ACQ=3, SWITCH=4, TRACK=5, RELOAD=6.
//  IDLE:
//   - core_rst=1, pgm=0.
//   - When start=1, snapshot all cfg_* inputs, clear fail and go to LOAD.
//   - start is ignored in every other state.
//  LOAD (6 cycles):
//   - pgm=1; param_sel steps 0..5, one per cycle, values taken from the snapshot.
//   - Alpha and beta use the acquisition values.
//   - First write is presented the cycle after start is sampled. core_rst=1.
//  RELEASE:
//   - pgm=0, core_rst=1 for RST_CYCLES cycles, then go to ACQ.
//  ACQ:
//   - core_rst=0.
//   - Lock counter: increments while filt_mag<=LOCK_TOL; clears to 0 on any out-of-window cycle.
//   - After LOCK_CNT consecutive in-window cycles, go to SWITCH.
//   - Timeout counter starts at 0 on entry to ACQ.
//   - When the timeout counter reaches ACQ_TIMEOUT-1 without lock: set fail=1 and go to IDLE.
//   - If lock and timeout occur in the same cycle, lock wins.
//  SWITCH (2 cycles):
//   - pgm=1, writes sel=1 (trk_a) then sel=2 (trk_b). Then go to TRACK.
//   - The core keeps running (core_rst=0).
//  TRACK:
//   - locked=1 from the first TRACK cycle.
//   - Unlock counter counts consecutive cycles with filt_mag>UNLOCK_TOL; clears on any
//     cycle with filt_mag<=UNLOCK_TOL.
//   - At UNLOCK_CNT consecutive cycles: locked=0, relock_cnt+=1 (saturating), go to RELOAD.
//  RELOAD (2 cycles):
//   - pgm=1, writes sel=1 (acq_a) then sel=2 (acq_b).
//   - Then go to ACQ with the lock and timeout counters cleared.
//  stop=1 in any state:
//   - Next cycle: state=IDLE, pgm=0, core_rst=1, locked=0.
//   - A partially completed write sequence is abandoned; fail is unchanged.
//  clr mid-sequence: all state returns to reset values immediately (asynchronous).
//  Magnitude compares are unsigned 5-bit. Counters are 16 bits wide and do not wrap
//   before their terminal counts.
// TESTING
//  1. Bring-up: start=1 with ndiv=4, acq_a=8, acq_b=4, offset=3, thresh=10, kdco=2.
//     Expect 6 pgm cycles with sel 0..5 and values 4,8,4,3,10,2, then 4 cycles core_rst=1,
//     then state=ACQ.
//  2. Lock: hold filt_mag=1 in ACQ. Expect SWITCH after exactly 64 cycles, writes (1,trk_a)
//     and (2,trk_b), then locked=1.
//  3. Lock counter restart: filt_mag=1 for 63 cycles, 3 for 1 cycle, then 1 again.
//     Expect lock only after a further 64 cycles.
//  4. Unlock: in TRACK, filt_mag=7 for 7 cycles then 0 -> stays locked.
//     filt_mag=7 for 8 cycles -> locked=0, relock_cnt=1, acquisition gains rewritten,
//     state=ACQ.
//  5. Timeout: filt_mag=20 constant in ACQ. Expect fail=1 and IDLE after 4096 cycles.
//     Next start clears fail.
//  6. Abort: assert stop during LOAD at sel=3. Expect IDLE next cycle with pgm=0,
//     core_rst=1. Assert clr during TRACK: all outputs at reset values immediately.

Source files
------------

// File: rtl/adpll_loop_sequencer.sv
// ADPLL bring-up and gain-scheduling sequencer: programs the top, releases its core reset,
// waits for lock on the filter output, then swaps between acquisition and tracking gains.
module adpll_loop_sequencer #(
    parameter int unsigned LOCK_TOL    = 2,
    parameter int unsigned LOCK_CNT    = 64,
    parameter int unsigned UNLOCK_TOL  = 6,
    parameter int unsigned UNLOCK_CNT  = 8,
    parameter int unsigned RST_CYCLES  = 4,
    parameter int unsigned ACQ_TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       i_start,
    input  logic       i_stop,
    input  logic [3:0] i_cfg_ndiv,
    input  logic [4:0] i_cfg_acq_a,
    input  logic [4:0] i_cfg_acq_b,
    input  logic [4:0] i_cfg_trk_a,
    input  logic [4:0] i_cfg_trk_b,
    input  logic [4:0] i_cfg_offset,
    input  logic [4:0] i_cfg_thresh,
    input  logic [4:0] i_cfg_kdco,
    input  logic [4:0] i_filt_mag,
    output logic       o_pgm,
    output logic [2:0] o_param_sel,
    output logic [4:0] o_pgm_value,
    output logic       o_core_rst,
    output logic       o_out_sel,
    output logic       o_locked,
    output logic       o_fail,
    output logic [7:0] o_relock_cnt,
    output logic [2:0] o_state
);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StLoad    = 3'd1,
        StRelease = 3'd2,
        StAcq     = 3'd3,
        StSwitch  = 3'd4,
        StTrack   = 3'd5,
        StReload  = 3'd6
    } state_t;

    state_t      r_state;
    logic        r_pgm;
    logic [2:0]  r_param_sel;
    logic [4:0]  r_pgm_value;
    logic        r_core_rst;
    logic        r_locked;
    logic        r_fail;
    logic [7:0]  r_relock_cnt;

    logic [3:0]  r_ndiv;
    logic [4:0]  r_acq_a;
    logic [4:0]  r_acq_b;
    logic [4:0]  r_trk_a;
    logic [4:0]  r_trk_b;
    logic [4:0]  r_offset;
    logic [4:0]  r_thresh;
    logic [4:0]  r_kdco;

    logic [15:0] r_rst_cnt;
    logic [15:0] r_lock_cnt;
    logic [15:0] r_to_cnt;
    logic [15:0] r_unl_cnt;

    logic        w_in_lock_win;
    logic        w_out_unlock_win;
    logic        w_lock_hit;
    logic        w_timeout;
    logic        w_unlock_hit;
    logic [2:0]  w_next_sel;
    logic [4:0]  w_next_value;

    assign w_in_lock_win    = i_filt_mag <= 5'(LOCK_TOL);
    assign w_out_unlock_win = i_filt_mag > 5'(UNLOCK_TOL);
    assign w_lock_hit       = w_in_lock_win && (r_lock_cnt == 16'(LOCK_CNT - 1));
    assign w_timeout        = r_to_cnt == 16'(ACQ_TIMEOUT - 1);
    assign w_unlock_hit     = w_out_unlock_win && (r_unl_cnt == 16'(UNLOCK_CNT - 1));
    assign w_next_sel       = r_param_sel + 3'd1;

    // LOAD always programs acquisition gains from the snapshot.
    always_comb begin
        w_next_value = {1'b0, r_ndiv};
        case (w_next_sel)
            3'd1:    w_next_value = r_acq_a;
            3'd2:    w_next_value = r_acq_b;
            3'd3:    w_next_value = r_offset;
            3'd4:    w_next_value = r_thresh;
            3'd5:    w_next_value = r_kdco;
            default: w_next_value = {1'b0, r_ndiv};
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state      <= StIdle;
            r_pgm        <= 1'b0;
            r_param_sel  <= 3'd0;
            r_pgm_value  <= 5'd0;
            r_core_rst   <= 1'b1;
            r_locked     <= 1'b0;
            r_fail       <= 1'b0;
            r_relock_cnt <= 8'd0;
            r_ndiv       <= 4'd0;
            r_acq_a      <= 5'd0;
            r_acq_b      <= 5'd0;
            r_trk_a      <= 5'd0;
            r_trk_b      <= 5'd0;
            r_offset     <= 5'd0;
            r_thresh     <= 5'd0;
            r_kdco       <= 5'd0;
            r_rst_cnt    <= 16'd0;
            r_lock_cnt   <= 16'd0;
            r_to_cnt     <= 16'd0;
            r_unl_cnt    <= 16'd0;
        end else if (i_stop) begin
            r_state    <= StIdle;
            r_pgm      <= 1'b0;
            r_core_rst <= 1'b1;
            r_locked   <= 1'b0;
            r_rst_cnt  <= 16'd0;
            r_lock_cnt <= 16'd0;
            r_to_cnt   <= 16'd0;
            r_unl_cnt  <= 16'd0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_pgm      <= 1'b0;
                    r_core_rst <= 1'b1;
                    if (i_start) begin
                        r_ndiv      <= i_cfg_ndiv;
                        r_acq_a     <= i_cfg_acq_a;
                        r_acq_b     <= i_cfg_acq_b;
                        r_trk_a     <= i_cfg_trk_a;
                        r_trk_b     <= i_cfg_trk_b;
                        r_offset    <= i_cfg_offset;
                        r_thresh    <= i_cfg_thresh;
                        r_kdco      <= i_cfg_kdco;
                        r_fail      <= 1'b0;
                        r_state     <= StLoad;
                        r_pgm       <= 1'b1;
                        r_param_sel <= 3'd0;
                        r_pgm_value <= {1'b0, i_cfg_ndiv};
                    end
                end
                StLoad: begin
                    if (r_param_sel == 3'd5) begin
                        r_state   <= StRelease;
                        r_pgm     <= 1'b0;
                        r_rst_cnt <= 16'd0;
                    end else begin
                        r_param_sel <= w_next_sel;
                        r_pgm_value <= w_next_value;
                    end
                end
                StRelease: begin
                    if (r_rst_cnt == 16'(RST_CYCLES - 1)) begin
                        r_state    <= StAcq;
                        r_core_rst <= 1'b0;
                        r_lock_cnt <= 16'd0;
                        r_to_cnt   <= 16'd0;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + 16'd1;
                    end
                end
                StAcq: begin
                    // Lock is checked first so it wins over a coincident timeout.
                    if (w_lock_hit) begin
                        r_state     <= StSwitch;
                        r_pgm       <= 1'b1;
                        r_param_sel <= 3'd1;
                        r_pgm_value <= r_trk_a;
                    end else if (w_timeout) begin
                        r_state    <= StIdle;
                        r_fail     <= 1'b1;
                        r_core_rst <= 1'b1;
                    end else begin
                        r_lock_cnt <= w_in_lock_win ? r_lock_cnt + 16'd1 : 16'd0;
                        r_to_cnt   <= r_to_cnt + 16'd1;
                    end
                end
                StSwitch: begin
                    if (r_param_sel == 3'd1) begin
                        r_param_sel <= 3'd2;
                        r_pgm_value <= r_trk_b;
                    end else begin
                        r_state   <= StTrack;
                        r_pgm     <= 1'b0;
                        r_locked  <= 1'b1;
                        r_unl_cnt <= 16'd0;
                    end
                end
                StTrack: begin
                    if (w_unlock_hit) begin
                        r_state     <= StReload;
                        r_locked    <= 1'b0;
                        r_pgm       <= 1'b1;
                        r_param_sel <= 3'd1;
                        r_pgm_value <= r_acq_a;
                        if (r_relock_cnt != 8'hFF) begin
                            r_relock_cnt <= r_relock_cnt + 8'd1;
                        end
                    end else begin
                        r_unl_cnt <= w_out_unlock_win ? r_unl_cnt + 16'd1 : 16'd0;
                    end
                end
                StReload: begin
                    if (r_param_sel == 3'd1) begin
                        r_param_sel <= 3'd2;
                        r_pgm_value <= r_acq_b;
                    end else begin
                        r_state    <= StAcq;
                        r_pgm      <= 1'b0;
                        r_lock_cnt <= 16'd0;
                        r_to_cnt   <= 16'd0;
                    end
                end
                default: begin
                    r_state    <= StIdle;
                    r_pgm      <= 1'b0;
                    r_core_rst <= 1'b1;
                    r_locked   <= 1'b0;
                end
            endcase
        end
    end

    assign o_pgm        = r_pgm;
    assign o_param_sel  = r_param_sel;
    assign o_pgm_value  = r_pgm_value;
    assign o_core_rst   = r_core_rst;
    assign o_out_sel    = 1'b0;
    assign o_locked     = r_locked;
    assign o_fail       = r_fail;
    assign o_relock_cnt = r_relock_cnt;
    assign o_state      = r_state;

endmodule

// File: tb/tb_adpll_loop_sequencer.sv
// Bench for adpll_loop_sequencer: bring-up vector table, directed lock/unlock/timeout/abort
// sequences, then random traffic checked every cycle against a write-queue reference model.
module tb_adpll_loop_sequencer;

    localparam int LOCK_TOL    = 2;
    localparam int LOCK_CNT    = 64;
    localparam int UNLOCK_TOL  = 6;
    localparam int UNLOCK_CNT  = 8;
    localparam int RST_CYCLES  = 4;
    localparam int ACQ_TIMEOUT = 4096;

    localparam int P_IDLE    = 0;
    localparam int P_LOAD    = 1;
    localparam int P_RELEASE = 2;
    localparam int P_ACQ     = 3;
    localparam int P_SWITCH  = 4;
    localparam int P_TRACK   = 5;
    localparam int P_RELOAD  = 6;

    logic       clk = 1'b0;
    logic       clr;
    logic       start;
    logic       stop;
    logic [3:0] cfg_ndiv;
    logic [4:0] cfg_acq_a;
    logic [4:0] cfg_acq_b;
    logic [4:0] cfg_trk_a;
    logic [4:0] cfg_trk_b;
    logic [4:0] cfg_offset;
    logic [4:0] cfg_thresh;
    logic [4:0] cfg_kdco;
    logic [4:0] filt_mag;
    logic       pgm;
    logic [2:0] param_sel;
    logic [4:0] pgm_value;
    logic       core_rst;
    logic       out_sel;
    logic       locked;
    logic       fail;
    logic [7:0] relock_cnt;
    logic [2:0] state;

    adpll_loop_sequencer #(
        .LOCK_TOL    (LOCK_TOL),
        .LOCK_CNT    (LOCK_CNT),
        .UNLOCK_TOL  (UNLOCK_TOL),
        .UNLOCK_CNT  (UNLOCK_CNT),
        .RST_CYCLES  (RST_CYCLES),
        .ACQ_TIMEOUT (ACQ_TIMEOUT)
    ) dut (
        .clk          (clk),
        .clr          (clr),
        .i_start      (start),
        .i_stop       (stop),
        .i_cfg_ndiv   (cfg_ndiv),
        .i_cfg_acq_a  (cfg_acq_a),
        .i_cfg_acq_b  (cfg_acq_b),
        .i_cfg_trk_a  (cfg_trk_a),
        .i_cfg_trk_b  (cfg_trk_b),
        .i_cfg_offset (cfg_offset),
        .i_cfg_thresh (cfg_thresh),
        .i_cfg_kdco   (cfg_kdco),
        .i_filt_mag   (filt_mag),
        .o_pgm        (pgm),
        .o_param_sel  (param_sel),
        .o_pgm_value  (pgm_value),
        .o_core_rst   (core_rst),
        .o_out_sel    (out_sel),
        .o_locked     (locked),
        .o_fail       (fail),
        .o_relock_cnt (relock_cnt),
        .o_state      (state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: pending register writes live in a queue; phases use the published codes.
    typedef struct {
        int sel;
        int val;
    } wr_t;

    wr_t m_q[$];
    int  m_phase, m_rel, m_run, m_age, m_bad;
    int  e_pgm, e_sel, e_val, e_rst, e_locked, e_fail, e_relock;
    int  s_ndiv, s_acq_a, s_acq_b, s_trk_a, s_trk_b, s_off, s_thr, s_kdco;

    task automatic m_reset();
        m_q.delete();
        m_phase  = P_IDLE;
        m_rel    = 0;
        m_run    = 0;
        m_age    = 0;
        m_bad    = 0;
        e_pgm    = 0;
        e_sel    = 0;
        e_val    = 0;
        e_rst    = 1;
        e_locked = 0;
        e_fail   = 0;
        e_relock = 0;
    endtask

    task automatic m_push(input int sel, input int val);
        wr_t w;
        w.sel = sel;
        w.val = val;
        m_q.push_back(w);
    endtask

    task automatic m_emit();
        wr_t w;
        w     = m_q.pop_front();
        e_pgm = 1;
        e_sel = w.sel;
        e_val = w.val;
    endtask

    task automatic m_edge(input bit st, input bit sp, input int fm);
        if (sp) begin
            m_q.delete();
            m_phase  = P_IDLE;
            e_pgm    = 0;
            e_rst    = 1;
            e_locked = 0;
            return;
        end
        case (m_phase)
            P_IDLE: if (st) begin
                s_ndiv  = int'(cfg_ndiv);
                s_acq_a = int'(cfg_acq_a);
                s_acq_b = int'(cfg_acq_b);
                s_trk_a = int'(cfg_trk_a);
                s_trk_b = int'(cfg_trk_b);
                s_off   = int'(cfg_offset);
                s_thr   = int'(cfg_thresh);
                s_kdco  = int'(cfg_kdco);
                e_fail  = 0;
                m_push(0, s_ndiv);
                m_push(1, s_acq_a);
                m_push(2, s_acq_b);
                m_push(3, s_off);
                m_push(4, s_thr);
                m_push(5, s_kdco);
                m_emit();
                m_phase = P_LOAD;
            end
            P_LOAD: if (m_q.size() != 0) m_emit();
                    else begin m_phase = P_RELEASE; e_pgm = 0; m_rel = 0; end
            P_RELEASE: begin
                m_rel++;
                if (m_rel == RST_CYCLES) begin
                    m_phase = P_ACQ; e_rst = 0; m_run = 0; m_age = 0;
                end
            end
            P_ACQ: begin
                m_age++;
                m_run = (fm <= LOCK_TOL) ? m_run + 1 : 0;
                if (m_run == LOCK_CNT) begin
                    m_push(1, s_trk_a);
                    m_push(2, s_trk_b);
                    m_emit();
                    m_phase = P_SWITCH;
                end else if (m_age == ACQ_TIMEOUT) begin
                    e_fail = 1; e_rst = 1; m_phase = P_IDLE;
                end
            end
            P_SWITCH: if (m_q.size() != 0) m_emit();
                      else begin m_phase = P_TRACK; e_pgm = 0; e_locked = 1; m_bad = 0; end
            P_TRACK: begin
                m_bad = (fm > UNLOCK_TOL) ? m_bad + 1 : 0;
                if (m_bad == UNLOCK_CNT) begin
                    e_locked = 0;
                    if (e_relock < 255) e_relock++;
                    m_push(1, s_acq_a);
                    m_push(2, s_acq_b);
                    m_emit();
                    m_phase = P_RELOAD;
                end
            end
            P_RELOAD: if (m_q.size() != 0) m_emit();
                      else begin m_phase = P_ACQ; e_pgm = 0; m_run = 0; m_age = 0; end
            default: m_phase = P_IDLE;
        endcase
    endtask

    task automatic chk_model();
        chk("m_state", int'(state), m_phase);
        chk("m_pgm", int'(pgm), e_pgm);
        chk("m_core_rst", int'(core_rst), e_rst);
        chk("m_locked", int'(locked), e_locked);
        chk("m_fail", int'(fail), e_fail);
        chk("m_relock_cnt", int'(relock_cnt), e_relock);
        chk("m_out_sel", int'(out_sel), 0);
        if (e_pgm == 1) begin
            chk("m_param_sel", int'(param_sel), e_sel);
            chk("m_pgm_value", int'(pgm_value), e_val);
        end
    endtask

    // Drive inputs, take one clock edge, advance the model and compare 1 time unit later.
    task automatic step(input bit st, input bit sp, input logic [4:0] fm);
        start    = st;
        stop     = sp;
        filt_mag = fm;
        @(posedge clk);
        m_edge(st, sp, int'(fm));
        #1;
        chk_model();
    endtask

    task automatic steps(input int n, input logic [4:0] fm);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, fm);
    endtask

    typedef struct {
        bit         st;
        bit         sp;
        logic [4:0] fm;
        int         e_state;
        int         e_pgm;
        int         e_sel;
        int         e_val;
        int         e_rst;
    } vec_t;

    vec_t vt[11];
    int   seg_left;
    int   seg_mode;
    logic [4:0] fm_r;

    initial begin
        // Bring-up table: 6 writes (ndiv, acq_a, acq_b, offset, thresh, kdco), 4 release cycles.
        vt[0]  = '{1'b1, 1'b0, 5'd0, 1, 1, 0, 4, 1};
        vt[1]  = '{1'b0, 1'b0, 5'd0, 1, 1, 1, 8, 1};
        vt[2]  = '{1'b0, 1'b0, 5'd0, 1, 1, 2, 4, 1};
        vt[3]  = '{1'b0, 1'b0, 5'd0, 1, 1, 3, 3, 1};
        vt[4]  = '{1'b0, 1'b0, 5'd0, 1, 1, 4, 10, 1};
        vt[5]  = '{1'b0, 1'b0, 5'd0, 1, 1, 5, 2, 1};
        vt[6]  = '{1'b0, 1'b0, 5'd0, 2, 0, 0, 0, 1};
        vt[7]  = '{1'b0, 1'b0, 5'd0, 2, 0, 0, 0, 1};
        vt[8]  = '{1'b0, 1'b0, 5'd0, 2, 0, 0, 0, 1};
        vt[9]  = '{1'b0, 1'b0, 5'd0, 2, 0, 0, 0, 1};
        vt[10] = '{1'b0, 1'b0, 5'd0, 3, 0, 0, 0, 0};

        clr        = 1'b1;
        start      = 1'b0;
        stop       = 1'b0;
        filt_mag   = 5'd0;
        cfg_ndiv   = 4'd4;
        cfg_acq_a  = 5'd8;
        cfg_acq_b  = 5'd4;
        cfg_trk_a  = 5'd5;
        cfg_trk_b  = 5'd1;
        cfg_offset = 5'd3;
        cfg_thresh = 5'd10;
        cfg_kdco   = 5'd2;
        m_reset();

        #12;
        chk("rst_state", int'(state), 0);
        chk("rst_pgm", int'(pgm), 0);
        chk("rst_sel_value", int'({param_sel, pgm_value}), 0);
        chk("rst_core_rst", int'(core_rst), 1);
        chk("rst_flags", int'({locked, fail, relock_cnt}), 0);
        clr = 1'b0;

        for (int i = 0; i < 11; i++) begin
            step(vt[i].st, vt[i].sp, vt[i].fm);
            chk("vec_state", int'(state), vt[i].e_state);
            chk("vec_pgm", int'(pgm), vt[i].e_pgm);
            chk("vec_core_rst", int'(core_rst), vt[i].e_rst);
            if (vt[i].e_pgm == 1) begin
                chk("vec_sel", int'(param_sel), vt[i].e_sel);
                chk("vec_value", int'(pgm_value), vt[i].e_val);
            end
        end

        // Lock after exactly LOCK_CNT in-window cycles, then tracking gains.
        steps(LOCK_CNT - 1, 5'd1);
        chk("lock_not_early", int'(state), P_ACQ);
        steps(1, 5'd1);
        chk("switch_state", int'(state), P_SWITCH);
        chk("switch_wr1", int'({pgm, param_sel, pgm_value}), int'({1'b1, 3'd1, 5'd5}));
        steps(1, 5'd0);
        chk("switch_wr2", int'({pgm, param_sel, pgm_value}), int'({1'b1, 3'd2, 5'd1}));
        steps(1, 5'd0);
        chk("track_locked", int'({state, locked}), int'({3'd5, 1'b1}));

        // UNLOCK_CNT-1 bad cycles do not unlock; UNLOCK_CNT do.
        steps(UNLOCK_CNT - 1, 5'd7);
        steps(1, 5'd0);
        chk("unlock_short_run", int'({state, locked}), int'({3'd5, 1'b1}));
        steps(UNLOCK_CNT - 1, 5'd7);
        chk("unlock_not_early", int'(locked), 1);
        steps(1, 5'd7);
        chk("reload_state", int'({state, locked}), int'({3'd6, 1'b0}));
        chk("reload_relock_cnt", int'(relock_cnt), 1);
        chk("reload_wr1", int'({pgm, param_sel, pgm_value}), int'({1'b1, 3'd1, 5'd8}));
        steps(1, 5'd0);
        chk("reload_wr2", int'({pgm, param_sel, pgm_value}), int'({1'b1, 3'd2, 5'd4}));
        steps(1, 5'd0);
        chk("reacq_state", int'({state, pgm, core_rst}), int'({3'd3, 1'b0, 1'b0}));

        // One out-of-window sample restarts the lock count.
        steps(LOCK_CNT - 1, 5'd1);
        steps(1, 5'd3);
        steps(LOCK_CNT - 1, 5'd1);
        chk("restart_not_early", int'(state), P_ACQ);
        steps(1, 5'd1);
        chk("restart_lock", int'(state), P_SWITCH);
        steps(2, 5'd0);
        chk("restart_track", int'(locked), 1);

        // Asynchronous clear in TRACK.
        #2;
        clr = 1'b1;
        #1;
        chk("clr_state", int'(state), 0);
        chk("clr_outputs", int'({pgm, param_sel, pgm_value, core_rst, locked, fail}),
            int'({1'b0, 3'd0, 5'd0, 1'b1, 1'b0, 1'b0}));
        chk("clr_relock_cnt", int'(relock_cnt), 0);
        #2;
        clr = 1'b0;
        m_reset();

        // Acquisition timeout.
        step(1'b1, 1'b0, 5'd20);
        steps(10, 5'd20);
        chk("to_in_acq", int'(state), P_ACQ);
        steps(ACQ_TIMEOUT - 1, 5'd20);
        chk("to_not_early", int'({state, fail}), int'({3'd3, 1'b0}));
        steps(1, 5'd20);
        chk("to_fail", int'({state, fail, core_rst}), int'({3'd0, 1'b1, 1'b1}));
        step(1'b0, 1'b1, 5'd0);
        chk("stop_keeps_fail", int'(fail), 1);
        step(1'b1, 1'b0, 5'd0);
        chk("start_clears_fail", int'({state, fail}), int'({3'd1, 1'b0}));

        // Abort during LOAD at sel=3.
        steps(3, 5'd0);
        chk("abort_at_sel3", int'({pgm, param_sel}), int'({1'b1, 3'd3}));
        step(1'b0, 1'b1, 5'd0);
        chk("abort_idle", int'({state, pgm, core_rst}), int'({3'd0, 1'b0, 1'b1}));

        // Random traffic: filter magnitude in segments of quiet/marginal/noisy behaviour.
        seg_left = 0;
        seg_mode = 0;
        for (int c = 0; c < 9000; c++) begin
            if (seg_left == 0) begin
                seg_left = int'($urandom_range(1, 120));
                seg_mode = int'($urandom_range(0, 3));
            end
            seg_left--;
            case (seg_mode)
                0:       fm_r = 5'($urandom_range(0, LOCK_TOL));
                1:       fm_r = 5'($urandom_range(0, UNLOCK_TOL));
                2:       fm_r = 5'($urandom_range(UNLOCK_TOL + 1, 31));
                default: fm_r = 5'($urandom_range(0, 31));
            endcase
            cfg_ndiv   = 4'($urandom);
            cfg_acq_a  = 5'($urandom);
            cfg_acq_b  = 5'($urandom);
            cfg_trk_a  = 5'($urandom);
            cfg_trk_b  = 5'($urandom);
            cfg_offset = 5'($urandom);
            cfg_thresh = 5'($urandom);
            cfg_kdco   = 5'($urandom);
            step(($urandom_range(0, 7) == 0), ($urandom_range(0, 399) == 0), fm_r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
